// File: rtl/debug_scan_controller_pkg.sv
// Shared definitions for the debug scan controller and the debug select
// register block: potential count, spike select code, select width and
// scan FSM state encoding.
package debug_scan_controller_pkg;

    localparam int unsigned NUM_MP    = 16;
    localparam int unsigned DBG_SEL_W = 8;
    localparam logic [DBG_SEL_W-1:0] SPIKE_SEL = 8'h10;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned OUT_IDX_W = 5;
    localparam int unsigned FCNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SEND    = 2'd3
    } scan_state_e;

    // Select code for a scan index: potentials map 1:1, the last index maps to the spike vector.
    function automatic logic [DBG_SEL_W-1:0] sel_code(
        input int unsigned           idx,
        input int unsigned           num_mp,
        input logic [DBG_SEL_W-1:0]  spike_sel
    );
        if (idx == num_mp) begin
            return spike_sel;
        end
        return DBG_SEL_W'(idx);
    endfunction

endpackage

// File: rtl/debug_scan_controller_if.sv
// Debug scan bus: select-register load port (dbg_en/dbg_cfg/dbg_data) and the
// captured-sample valid/ready stream (out_*).
//   master : scan controller side (drives select load and sample stream)
//   slave  : debug mux + downstream consumer side
interface debug_scan_controller_if;
    import debug_scan_controller_pkg::*;

    logic                  dbg_en;
    logic [DBG_SEL_W-1:0]  dbg_cfg;
    logic [DATA_W-1:0]     dbg_data;
    logic [DATA_W-1:0]     out_data;
    logic [OUT_IDX_W-1:0]  out_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output dbg_en, dbg_cfg, out_data, out_idx, out_valid, out_last,
        input  dbg_data, out_ready
    );

    modport slave (
        input  dbg_en, dbg_cfg, out_data, out_idx, out_valid, out_last,
        output dbg_data, out_ready
    );

endinterface

// File: rtl/debug_scan_controller.sv
// Debug scan controller: walks the debug select register through all
// membrane-potential codes and then the spike vector, capturing one sample
// per select and streaming it out with valid/ready.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin one frame (only honoured in IDLE)
//   continuous   chain the next frame on the last-beat handshake
//   bus          select load + sample stream (master modport)
//   busy         FSM not in IDLE
//   frame_count  completed frames, wrapping
module debug_scan_controller
    import debug_scan_controller_pkg::*;
#(
    parameter int unsigned           NUM_MP    = debug_scan_controller_pkg::NUM_MP,
    parameter logic [DBG_SEL_W-1:0]  SPIKE_SEL = debug_scan_controller_pkg::SPIKE_SEL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        continuous,
    debug_scan_controller_if.master     bus,
    output logic                        busy,
    output logic [FCNT_W-1:0]           frame_count
);

    localparam int unsigned IDX_W = $clog2(NUM_MP + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MP);

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [OUT_IDX_W-1:0]   out_idx_q, out_idx_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   dbg_en_q, dbg_en_d;
    logic [DBG_SEL_W-1:0]   dbg_cfg_q, dbg_cfg_d;
    logic                   busy_q, busy_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            dbg_en_q    <= 1'b0;
            dbg_cfg_q   <= 8'h00;
            busy_q      <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            dbg_en_q    <= dbg_en_d;
            dbg_cfg_q   <= dbg_cfg_d;
            busy_q      <= busy_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Next state, index/frame counters, and output values decoded from the
    // next state so the registered outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        fcnt_d      = fcnt_q;
        dbg_cfg_d   = dbg_cfg_q;
        dbg_en_d    = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Select register was loaded at the end of LOAD; mux output is settled.
                out_data_d = bus.dbg_data;
                out_idx_d  = OUT_IDX_W'(idx_q);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                        if (continuous) begin
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dbg_en_d    = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_SEND);
        out_last_d  = (state_d == ST_SEND) && (idx_d == IDX_LAST);
        busy_d      = (state_d != ST_IDLE);
        // dbg_cfg only changes when a load is about to be issued.
        if (dbg_en_d) begin
            dbg_cfg_d = sel_code(32'(idx_d), NUM_MP, SPIKE_SEL);
        end
    end

    assign bus.dbg_en    = dbg_en_q;
    assign bus.dbg_cfg   = dbg_cfg_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_debug_scan_controller.sv
// Bench for debug_scan_controller: models the debug select register and mux,
// and checks every beat of each frame against the expected scan sequence.
module tb_debug_scan_controller;
    import debug_scan_controller_pkg::*;

    logic clk;
    logic rst;
    logic start;
    logic continuous;
    logic busy;
    logic [7:0] frame_count;

    debug_scan_controller_if bus_if ();

    debug_scan_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .bus         (bus_if),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] exp_fc = 8'h00;
    logic [7:0] mux_tab [0:NUM_MP];
    logic [7:0] sel_q = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debug select register + mux environment model.
    always @(posedge clk) begin
        if (bus_if.dbg_en) sel_q <= bus_if.dbg_cfg;
    end
    assign bus_if.dbg_data = (sel_q == SPIKE_SEL) ? mux_tab[NUM_MP] :
                             (sel_q < 8'(NUM_MP)) ? mux_tab[sel_q[4:0]] : 8'h00;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dbg_en"},  32'(bus_if.dbg_en),    0);
        chk({tag, "_dbg_cfg"}, 32'(bus_if.dbg_cfg),   0);
        chk({tag, "_data"},    32'(bus_if.out_data),  0);
        chk({tag, "_idx"},     32'(bus_if.out_idx),   0);
        chk({tag, "_valid"},   32'(bus_if.out_valid), 0);
        chk({tag, "_last"},    32'(bus_if.out_last),  0);
        chk({tag, "_busy"},    32'(busy),             0);
        chk({tag, "_fcnt"},    32'(frame_count),      0);
    endtask

    // Called at the negedge of the LOAD cycle of beat k; returns at the
    // negedge after the handshake.
    task automatic collect_beat(input int k, input int stall);
        logic [7:0] cfg;
        logic       last;
        cfg  = (k == int'(NUM_MP)) ? SPIKE_SEL : 8'(k);
        last = (k == int'(NUM_MP));
        chk($sformatf("load_en[%0d]", k),    32'(bus_if.dbg_en),    1);
        chk($sformatf("load_cfg[%0d]", k),   32'(bus_if.dbg_cfg),   32'(cfg));
        chk($sformatf("load_valid[%0d]", k), 32'(bus_if.out_valid), 0);
        chk($sformatf("load_busy[%0d]", k),  32'(busy),             1);
        tick();
        chk($sformatf("cap_en[%0d]", k),     32'(bus_if.dbg_en),    0);
        chk($sformatf("cap_cfg[%0d]", k),    32'(bus_if.dbg_cfg),   32'(cfg));
        chk($sformatf("cap_valid[%0d]", k),  32'(bus_if.out_valid), 0);
        tick();
        chk($sformatf("send_valid[%0d]", k), 32'(bus_if.out_valid), 1);
        chk($sformatf("send_data[%0d]", k),  32'(bus_if.out_data),  32'(mux_tab[k]));
        chk($sformatf("send_idx[%0d]", k),   32'(bus_if.out_idx),   32'(k));
        chk($sformatf("send_last[%0d]", k),  32'(bus_if.out_last),  32'(last));
        chk($sformatf("send_en[%0d]", k),    32'(bus_if.dbg_en),    0);
        chk($sformatf("send_cfg[%0d]", k),   32'(bus_if.dbg_cfg),   32'(cfg));
        if (stall > 0) begin
            bus_if.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                chk($sformatf("hold_valid[%0d]", k), 32'(bus_if.out_valid), 1);
                chk($sformatf("hold_data[%0d]", k),  32'(bus_if.out_data),  32'(mux_tab[k]));
                chk($sformatf("hold_idx[%0d]", k),   32'(bus_if.out_idx),   32'(k));
                chk($sformatf("hold_last[%0d]", k),  32'(bus_if.out_last),  32'(last));
                chk($sformatf("hold_en[%0d]", k),    32'(bus_if.dbg_en),    0);
            end
            bus_if.out_ready = 1'b1;
        end
        tick();
    endtask

    task automatic run_frame(input bit do_start, input int stall_idx, input int stall_len,
                             input bit rnd_stall, input int poke_idx, input int drop_idx);
        int st;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int k = 0; k <= int'(NUM_MP); k++) begin
            if (k == poke_idx) start = 1'b1;
            if (k == drop_idx) continuous = 1'b0;
            if (k == stall_idx)  st = stall_len;
            else if (rnd_stall)  st = int'($urandom_range(0, 3));
            else                 st = 0;
            collect_beat(k, st);
            start = 1'b0;
        end
        exp_fc = 8'(exp_fc + 8'd1);
        if (!continuous) begin
            chk("frame_end_busy",  32'(busy),             0);
            chk("frame_end_valid", 32'(bus_if.out_valid), 0);
        end
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fc = 8'h00;
        tick();
    endtask

    initial begin
        int c0;
        bit first;
        for (int k = 0; k < int'(NUM_MP); k++) mux_tab[k] = 8'(k + 1);
        mux_tab[NUM_MP] = 8'hA5;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Basic frame and latency.
        c0 = cyc;
        run_frame(1'b1, -1, 0, 1'b0, -1, -1);
        chk("frame_cycles", 32'(cyc - c0), 52);
        chk("basic_fcnt", 32'(frame_count), 1);

        // Backpressure at idx 3.
        run_frame(1'b1, 3, 5, 1'b0, -1, -1);

        // Three continuous frames, continuous dropped during the third.
        do_reset();
        continuous = 1'b1;
        run_frame(1'b1, -1, 0, 1'b0, -1, -1);
        run_frame(1'b0, -1, 0, 1'b0, -1, -1);
        run_frame(1'b0, -1, 0, 1'b0, -1, 8);
        chk("cont_fcnt", 32'(frame_count), 3);

        // Start pulsed mid-frame is ignored.
        run_frame(1'b1, -1, 0, 1'b0, 7, -1);
        repeat (6) tick();
        chk("no_extra_frame_busy", 32'(busy), 0);
        chk("no_extra_frame_fcnt", 32'(frame_count), 4);

        // Asynchronous reset in CAPTURE at idx 9.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) collect_beat(k, 0);
        chk("pre_rst_cfg", 32'(bus_if.dbg_cfg), 9);
        tick();
        #1 rst = 1'b1;
        exp_fc = 8'h00;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        tick();
        chk_reset_outputs("post_rst");
        run_frame(1'b1, -1, 0, 1'b0, -1, -1);

        // Random mux contents and random backpressure.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k <= int'(NUM_MP); k++) mux_tab[k] = 8'($urandom);
            run_frame(1'b1, -1, 0, 1'b1, -1, -1);
        end

        // Frame counter wrap.
        continuous = 1'b1;
        first = 1'b1;
        while (exp_fc != 8'd255) begin
            run_frame(first, -1, 0, 1'b0, -1, -1);
            first = 1'b0;
        end
        chk("pre_wrap_fcnt", 32'(frame_count), 255);
        run_frame(1'b0, -1, 0, 1'b0, -1, 8);
        chk("wrap_fcnt", 32'(frame_count), 0);
        chk("wrap_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
